systolic_skew_feeder: RTL

SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

---
 rtl/systolic_skew_feeder_pkg.sv | 19 +
 rtl/systolic_skew_feeder_delay_line.sv | 34 +++
 rtl/systolic_skew_feeder.sv | 101 ++++++++++
 3 files changed

// File: rtl/systolic_skew_feeder_pkg.sv
// rtl/systolic_skew_feeder_pkg.sv - shared FSM encoding and default widths for the skew feeder
package systolic_skew_feeder_pkg;

    localparam int ROW_NUM_DEFAULT          = 16;
    localparam int INPUT_DATA_WIDTH_DEFAULT = 8;
    localparam int K_WIDTH_DEFAULT          = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } feeder_state_t;

    // Drain counter must hold ROW_NUM-1; keep at least one bit for a single-row array.
    function automatic int drain_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_delay_line.sv
// rtl/systolic_skew_feeder_delay_line.sv - fixed-depth register chain carrying {enable, data} per row
module skew_delay_line
    import systolic_skew_feeder_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = INPUT_DATA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_enable,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_enable,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= {in_enable, in_data};
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out_enable = stage[DEPTH-1][WIDTH];
    assign out_data   = stage[DEPTH-1][WIDTH-1:0];

endmodule

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - feeds activation vectors into a systolic array with per-row skew
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int ROW_NUM          = ROW_NUM_DEFAULT,
    parameter int INPUT_DATA_WIDTH = INPUT_DATA_WIDTH_DEFAULT,
    parameter int K_WIDTH          = K_WIDTH_DEFAULT
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start,
    input  logic [K_WIDTH-1:0]                  k_len,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [ROW_NUM*INPUT_DATA_WIDTH-1:0] in_vec,
    output logic [ROW_NUM*INPUT_DATA_WIDTH-1:0] out_a_bus,
    output logic [ROW_NUM-1:0]                  out_enable,
    output logic                                busy,
    output logic                                done
);

    localparam int W  = INPUT_DATA_WIDTH;
    localparam int DW = drain_width(ROW_NUM);

    feeder_state_t      state;
    logic [K_WIDTH-1:0] acc_cnt;
    logic [DW-1:0]      drain_cnt;
    logic               accept;

    assign accept = in_valid & in_ready;

    // done is raised one edge early so it lines up with the last element leaving row ROW_NUM-1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            acc_cnt   <= '0;
            drain_cnt <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && (k_len != '0)) begin
                        state    <= ST_FEED;
                        acc_cnt  <= k_len;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_FEED: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt - 1'b1;
                        if (acc_cnt == K_WIDTH'(1)) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= DW'(ROW_NUM - 1);
                            in_ready  <= 1'b0;
                            done      <= (ROW_NUM == 1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                        done      <= (drain_cnt == DW'(1));
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    for (genvar r = 0; r < ROW_NUM; r++) begin : g_row
        logic         row_en;
        logic [W-1:0] row_data;

        skew_delay_line #(
            .DEPTH (r + 1),
            .WIDTH (W)
        ) u_line (
            .clk        (clk),
            .rstn       (rstn),
            .in_enable  (accept),
            .in_data    (accept ? in_vec[r*W +: W] : '0),
            .out_enable (row_en),
            .out_data   (row_data)
        );

        assign out_enable[r]       = row_en;
        assign out_a_bus[r*W +: W] = row_en ? row_data : '0;
    end

endmodule
